// File: rtl/mul_share_pkg.sv
// Shared definitions for the mul_share_arbiter slice: datapath widths, FSM encoding
// and the round-robin pointer advance helper.
package mul_share_pkg;

  localparam int MUL_W  = 32;
  localparam int PROD_W = 64;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Pointer moves just past the granted requester so it gets lowest priority next time.
  function automatic logic [IDX_W-1:0] next_rr_ptr(input logic [IDX_W-1:0] g, input int nreq);
    if (int'(g) >= nreq - 1) return '0;
    return g + IDX_W'(1);
  endfunction

endpackage

// File: rtl/multiplier.sv
// Combinational 32x32 unsigned multiplier producing the full 64-bit product.
module multiplier (
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic [63:0] result
);

  assign result = {32'd0, X} * {32'd0, Y};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above i_ptr, wrapping at NREQ.
module rr_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  localparam int PW = IDX_W + 1;

  logic [PW-1:0] w_pos;

  always_comb begin
    w_pos   = '0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = {1'b0, i_ptr} + PW'(k);
      if (w_pos >= PW'(NREQ)) w_pos = w_pos - PW'(NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if (!o_any && i_req[j] && (w_pos[IDX_W-1:0] == IDX_W'(j))) begin
          o_any      = 1'b1;
          o_idx      = IDX_W'(j);
          o_grant[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one 32x32 multiplier among NREQ requesters, operands held LAT cycles.
// Optional MUL_SHARE_ARB_PERF_EN adds perf_ops / perf_wait counters.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*MUL_W-1:0] req_x,
  input  logic [NREQ*MUL_W-1:0] req_y,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [PROD_W-1:0]     rsp_result
`ifdef MUL_SHARE_ARB_PERF_EN
  ,
  output logic [31:0]           perf_ops,
  output logic [31:0]           perf_wait
`endif
);

  state_t             r_state;
  state_t             w_nextState;
  logic [IDX_W-1:0]   r_rrPtr;
  logic [IDX_W-1:0]   r_owner;
  logic [3:0]         r_cnt;
  logic [MUL_W-1:0]   r_opX;
  logic [MUL_W-1:0]   r_opY;
  logic [PROD_W-1:0]  r_resQ;

  logic [NREQ-1:0]    w_grant;
  logic [IDX_W-1:0]   w_gntIdx;
  logic               w_any;
  logic [MUL_W-1:0]   w_selX;
  logic [MUL_W-1:0]   w_selY;
  logic [PROD_W-1:0]  w_product;
  logic               w_ownerReady;
  logic               w_accept;
  logic               w_capture;
  logic               w_rspDone;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rrPtr),
    .o_grant (w_grant),
    .o_idx   (w_gntIdx),
    .o_any   (w_any)
  );

  multiplier u_mul (
    .X      (r_opX),
    .Y      (r_opY),
    .result (w_product)
  );

  always_comb begin
    w_selX       = '0;
    w_selY       = '0;
    w_ownerReady = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_gntIdx == IDX_W'(j)) begin
        w_selX = req_x[MUL_W*j +: MUL_W];
        w_selY = req_y[MUL_W*j +: MUL_W];
      end
      if (r_owner == IDX_W'(j)) w_ownerReady = rsp_ready[j];
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_rspDone   = 1'b0;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_result  = '0;
    case (r_state)
      IDLE: begin
        if (w_any && rst_n) begin
          w_accept    = 1'b1;
          req_ready   = w_grant;
          w_nextState = EXEC;
        end
      end
      EXEC: begin
        if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_nextState = RESP;
        end
      end
      RESP: begin
        for (int j = 0; j < NREQ; j++) begin
          if (r_owner == IDX_W'(j)) rsp_valid[j] = 1'b1;
        end
        rsp_result = r_resQ;
        if (w_ownerReady) begin
          w_rspDone   = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Operands stay frozen through EXEC so the multiplier path can be multicycle-constrained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rrPtr <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_opX   <= '0;
      r_opY   <= '0;
      r_resQ  <= '0;
    end else begin
      if (w_accept) begin
        r_opX   <= w_selX;
        r_opY   <= w_selY;
        r_owner <= w_gntIdx;
        r_rrPtr <= next_rr_ptr(w_gntIdx, NREQ);
        r_cnt   <= 4'(LAT - 1);
      end else if (r_state == EXEC && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) r_resQ <= w_product;
    end
  end

`ifdef MUL_SHARE_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ops  <= '0;
      perf_wait <= '0;
    end else begin
      if (w_rspDone) perf_ops <= perf_ops + 32'd1;
      if ((|req_valid) && (req_ready == '0) && (perf_wait != 32'hFFFF_FFFF))
        perf_wait <= perf_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: one LAT=1 instance for the main traffic and
// one LAT=4 instance for the reset-during-EXEC case.
module tb_mul_share_arbiter;

  typedef struct {
    int          idx;
    logic [63:0] prod;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstN;
  logic [3:0]   reqValid, reqReady, rspValid, rspReady;
  logic [127:0] reqX, reqY;
  logic [63:0]  rspResult;
  logic         rst4N;
  logic [3:0]   req4Valid, req4Ready, rsp4Valid, rsp4Ready;
  logic [127:0] req4X, req4Y;
  logic [63:0]  rsp4Result;
`ifdef MUL_SHARE_ARB_PERF_EN
  logic [31:0]  perfOps, perfWait, perfOps4, perfWait4;
`endif

  exp_t q1[$];
  exp_t q4[$];
  exp_t mon1E, mon4E;
  int   nCompared = 0;
  int   nMismatched = 0;
  bit   monOn = 1'b0;
  int   waited;

  always #5 clk = ~clk;

  mul_share_arbiter #(.NREQ(4), .LAT(1)) dut (
    .clk(clk), .rst_n(rstN),
    .req_valid(reqValid), .req_ready(reqReady), .req_x(reqX), .req_y(reqY),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_result(rspResult)
`ifdef MUL_SHARE_ARB_PERF_EN
    , .perf_ops(perfOps), .perf_wait(perfWait)
`endif
  );

  mul_share_arbiter #(.NREQ(4), .LAT(4)) dut4 (
    .clk(clk), .rst_n(rst4N),
    .req_valid(req4Valid), .req_ready(req4Ready), .req_x(req4X), .req_y(req4Y),
    .rsp_valid(rsp4Valid), .rsp_ready(rsp4Ready), .rsp_result(rsp4Result)
`ifdef MUL_SHARE_ARB_PERF_EN
    , .perf_ops(perfOps4), .perf_wait(perfWait4)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] x, input logic [31:0] y,
                               input logic [63:0] prod);
    exp_t e;
    reqValid[idx]        = 1'b1;
    reqX[32*idx +: 32]   = x;
    reqY[32*idx +: 32]   = y;
    e.idx  = idx;
    e.prod = prod;
    q1.push_back(e);
  endtask

  // Returns at posedge+1 after the grant edge; a missing grant shows up as a failed compare.
  task automatic waitGrant(input int idx, input bit keep, input string name, output int cycles);
    bit got;
    got    = 1'b0;
    cycles = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (reqReady != 4'd0) got = 1'b1;
      else cycles++;
    end
    checkOutput(name, 64'(reqReady), 64'(4'b0001 << idx));
    @(posedge clk); #1;
    if (!keep) reqValid[idx] = 1'b0;
  endtask

  task automatic waitEmpty(input int sel, input string name);
    for (int c = 0; c < 60; c++) begin
      if ((sel == 1 ? q1.size() : q4.size()) == 0) break;
      @(negedge clk);
    end
    checkOutput(name, 64'(sel == 1 ? q1.size() : q4.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      if (rspValid == 4'd0) checkOutput("idle rsp_result", rspResult, 64'd0);
      else if (q1.size() == 0) checkOutput("unexpected rsp_valid", 64'(rspValid), 64'd0);
      else if ((rspValid & rspReady) != 4'd0) begin
        mon1E = q1.pop_front();
        checkOutput("rsp owner", 64'(rspValid), 64'(4'b0001 << mon1E.idx));
        checkOutput("rsp result", rspResult, mon1E.prod);
      end
    end
  end

  always @(negedge clk) begin
    if (monOn) begin
      if (rsp4Valid == 4'd0) checkOutput("lat4 idle rsp_result", rsp4Result, 64'd0);
      else if (q4.size() == 0) checkOutput("lat4 unexpected rsp_valid", 64'(rsp4Valid), 64'd0);
      else if ((rsp4Valid & rsp4Ready) != 4'd0) begin
        mon4E = q4.pop_front();
        checkOutput("lat4 rsp owner", 64'(rsp4Valid), 64'(4'b0001 << mon4E.idx));
        checkOutput("lat4 rsp result", rsp4Result, mon4E.prod);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rstN      = 1'b0;
    rst4N     = 1'b0;
    reqValid  = 4'hF;
    reqX      = {4{32'h1234_5678}};
    reqY      = {4{32'h0000_0010}};
    rspReady  = 4'd0;
    req4Valid = 4'd0;
    req4X     = '0;
    req4Y     = '0;
    rsp4Ready = 4'hF;

    // Reset held with every requester asking.
    @(posedge clk); #1;
    monOn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("reset req_ready", 64'(reqReady), 64'd0);
      checkOutput("reset rsp_valid", 64'(rspValid), 64'd0);
      checkOutput("reset rsp_result", rspResult, 64'd0);
      @(posedge clk); #1;
    end
    reqValid = 4'd0;
    rstN     = 1'b1;
    rst4N    = 1'b1;

    // Single op with response held off.
    applyStimulus(0, 32'd3, 32'd7, 64'd21);
    waitGrant(0, 1'b0, "single grant", waited);
    checkOutput("single grant same cycle", 64'(waited), 64'd0);
    @(negedge clk);
    checkOutput("single exec rsp_valid", 64'(rspValid), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("single rsp_valid held", 64'(rspValid), 64'b0001);
      checkOutput("single rsp_result held", rspResult, 64'd21);
    end
    @(posedge clk); #1;
    rspReady = 4'b0001;
    @(posedge clk); #1;
    rspReady = 4'd0;

    // Fresh pointer for the fairness rotation.
    rstN = 1'b0;
    @(posedge clk); #1;
    rstN     = 1'b1;
    rspReady = 4'hF;
    applyStimulus(0, 32'd5, 32'd6, 64'd30);
    applyStimulus(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    applyStimulus(2, 32'd0, 32'hDEAD_BEEF, 64'd0);
    applyStimulus(3, 32'h8000_0000, 32'd2, 64'h1_0000_0000);
    applyStimulus(0, 32'd5, 32'd6, 64'd30);
    waitGrant(0, 1'b1, "fair grant 0", waited);
    waitGrant(1, 1'b0, "fair grant 1", waited);
    waitGrant(2, 1'b0, "fair grant 2", waited);
    waitGrant(3, 1'b0, "fair grant 3", waited);
    waitGrant(0, 1'b0, "fair grant 0 again", waited);
    applyStimulus(2, 32'd12, 32'd12, 64'd144);
    applyStimulus(0, 32'd9, 32'd9, 64'd81);
    waitGrant(2, 1'b0, "ptr1 grant req2 first", waited);
    waitGrant(0, 1'b0, "ptr1 grant req0 second", waited);
    waitEmpty(1, "fairness drain");

    // Backpressure on owner 1; rsp_ready[3] alone must not release it.
    rspReady = 4'b1000;
    applyStimulus(1, 32'd100, 32'd200, 64'd20000);
    waitGrant(1, 1'b0, "bp grant 1", waited);
    applyStimulus(3, 32'd7, 32'd11, 64'd77);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("bp rsp_valid stable", 64'(rspValid), 64'b0010);
      checkOutput("bp rsp_result stable", rspResult, 64'd20000);
      checkOutput("bp req_ready blocked", 64'(reqReady), 64'd0);
    end
    @(posedge clk); #1;
    rspReady = 4'b1010;
    @(negedge clk);
    checkOutput("bp release cycle req_ready", 64'(reqReady), 64'd0);
    @(negedge clk);
    checkOutput("bp req3 granted after release", 64'(reqReady), 64'b1000);
    @(posedge clk); #1;
    reqValid[3] = 1'b0;
    waitEmpty(1, "bp drain");
    rspReady = 4'd0;

    // LAT=4: reset lands while the op is still in EXEC.
    req4Valid[0]    = 1'b1;
    req4X[31:0]     = 32'd11;
    req4Y[31:0]     = 32'd13;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req4Ready != 4'd0) break;
    end
    checkOutput("lat4 first grant", 64'(req4Ready), 64'b0001);
    @(posedge clk); #1;
    req4Valid = 4'd0;
    @(posedge clk); #1;
    rst4N = 1'b0;
    @(posedge clk); #1;
    rst4N = 1'b1;
    repeat (10) @(negedge clk);

    mon4E.idx  = 1;
    mon4E.prod = 64'd42;
    q4.push_back(mon4E);
    @(posedge clk); #1;
    req4Valid[1]    = 1'b1;
    req4X[63:32]    = 32'd6;
    req4Y[63:32]    = 32'd7;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req4Ready != 4'd0) break;
    end
    checkOutput("lat4 grant after reset", 64'(req4Ready), 64'b0010);
    @(posedge clk); #1;
    req4Valid = 4'd0;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n++;
      if (rsp4Valid != 4'd0) break;
    end
    checkOutput("lat4 accept-to-rsp cycles", 64'(n), 64'd5);
    waitEmpty(4, "lat4 drain");

`ifdef MUL_SHARE_ARB_PERF_EN
    @(negedge clk);
    checkOutput("perf_ops after fairness+bp", 64'(perfOps), 64'd9);
    checkOutput("lat4 perf_ops skips dropped op", 64'(perfOps4), 64'd1);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
